// File: rtl/xnor_seq_arbiter_pkg.sv
// Shared types and constants for the bit-serial XNOR equality arbiter.
package xnor_seq_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/xnor_seq_arbiter_cell.sv
// xnor_nor_cell: 1-bit XNOR built from six NOR gates only.
module xnor_nor_cell (
  input  logic a,
  input  logic b,
  output logic s
);

  logic na, nb, n_or, n_and, x;

  // Inverters, then XOR = NOR(a NOR b, ~a NOR ~b), then a final NOR-inverter.
  always_comb begin
    na    = ~(a | a);
    nb    = ~(b | b);
    n_or  = ~(a | b);
    n_and = ~(na | nb);
    x     = ~(n_or | n_and);
    s     = ~(x | x);
  end

endmodule

// File: rtl/xnor_seq_arbiter.sv
// Two-requester bit-serial equality engine sharing one NOR-only XNOR cell.
// Define XNOR_SEQ_EARLY_EXIT_EN to stop comparing at the first mismatching bit.
module xnor_seq_arbiter
  import xnor_seq_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic             rsp_eq,
  output logic [CNT_W-1:0] rsp_match_cnt,
  output logic             busy
);

  localparam int unsigned IDX_W = $clog2(WIDTH);

  state_t           state, next_state;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] match_cnt, cnt_inc;
  logic             id_r, last_grant;
  logic             grant0, grant1, cell_s, stop;

  xnor_nor_cell u_cell (
    .a (a_sh[0]),
    .b (b_sh[0]),
    .s (cell_s)
  );

  always_comb begin
    grant0     = req0_valid && (!req1_valid || last_grant == REQ1);
    grant1     = req1_valid && (!req0_valid || last_grant == REQ0);
    req0_ready = (state == IDLE) && grant0;
    req1_ready = (state == IDLE) && grant1;
    rsp_valid  = (state == DONE);
    busy       = (state != IDLE);
    cnt_inc    = match_cnt + CNT_W'(cell_s);
`ifdef XNOR_SEQ_EARLY_EXIT_EN
    stop = (state == SHIFT) && ((idx == IDX_W'(WIDTH - 1)) || !cell_s);
`else
    stop = (state == SHIFT) && (idx == IDX_W'(WIDTH - 1));
`endif
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req0_ready || req1_ready) next_state = SHIFT;
      SHIFT:   if (stop) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      a_sh          <= '0;
      b_sh          <= '0;
      idx           <= '0;
      match_cnt     <= '0;
      id_r          <= REQ0;
      last_grant    <= REQ1;
      rsp_id        <= REQ0;
      rsp_eq        <= 1'b0;
      rsp_match_cnt <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            a_sh       <= req1_ready ? req1_a : req0_a;
            b_sh       <= req1_ready ? req1_b : req0_b;
            id_r       <= req1_ready ? REQ1 : REQ0;
            last_grant <= req1_ready ? REQ1 : REQ0;
            idx        <= '0;
            match_cnt  <= '0;
          end
        end
        SHIFT: begin
          a_sh      <= a_sh >> 1;
          b_sh      <= b_sh >> 1;
          idx       <= idx + IDX_W'(1);
          match_cnt <= cnt_inc;
          // On an early mismatch cnt_inc equals the leading-match count, so eq is 0.
          if (stop) begin
            rsp_id        <= id_r;
            rsp_match_cnt <= cnt_inc;
            rsp_eq        <= (cnt_inc == CNT_W'(WIDTH));
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xnor_seq_arbiter.sv
// Directed, table-driven self-checking bench for xnor_seq_arbiter (WIDTH=8).
module tb_xnor_seq_arbiter;

`ifdef XNOR_SEQ_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready;
  logic       rsp_valid, rsp_id, rsp_eq, busy;
  logic [3:0] rsp_match_cnt;
  logic       ca, cb, cs;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  xnor_seq_arbiter #(.WIDTH(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .req0_valid    (req0_valid),
    .req0_a        (req0_a),
    .req0_b        (req0_b),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_a        (req1_a),
    .req1_b        (req1_b),
    .req1_ready    (req1_ready),
    .rsp_valid     (rsp_valid),
    .rsp_id        (rsp_id),
    .rsp_eq        (rsp_eq),
    .rsp_match_cnt (rsp_match_cnt),
    .busy          (busy)
  );

  xnor_nor_cell u_cell_chk (.a(ca), .b(cb), .s(cs));

  typedef struct {
    logic        v0, v1;
    logic [7:0]  a, b;
    logic        id, eq;
    logic [3:0]  cnt_full, cnt_ee;
    int unsigned lat_ee;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic run_req(input string nm, input logic v0, input logic v1,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] a1, input logic [7:0] b1,
                         input logic eid, input logic eeq, input logic [3:0] ecnt,
                         input int unsigned elat);
    int unsigned n;
    logic        got_id;
    req0_valid = v0; req0_a = a;  req0_b = b;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    #1;
    n = 0;
    while (!(req0_ready || req1_ready) && n < 30) begin
      step();
      n++;
    end
    check({nm, " handshake"}, {31'd0, req0_ready || req1_ready}, 32'd1);
    check({nm, " one_ready"}, {31'd0, req0_ready && req1_ready}, 32'd0);
    got_id = req1_ready;
    check({nm, " grant_id"}, {31'd0, got_id}, {31'd0, eid});
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 40) begin
      if (!busy) begin
        errors++; checks++;
        $display("FAIL %s busy: got 0 expected 1 at cycle A+%0d", nm, n);
      end
      step();
      n++;
    end
    check({nm, " rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({nm, " latency"}, n, elat);
    check({nm, " busy_done"}, {31'd0, busy}, 32'd1);
    check({nm, " rsp_id"}, {31'd0, rsp_id}, {31'd0, eid});
    check({nm, " rsp_eq"}, {31'd0, rsp_eq}, {31'd0, eeq});
    check({nm, " rsp_cnt"}, {28'd0, rsp_match_cnt}, {28'd0, ecnt});
    step();
    check({nm, " idle_busy"}, {31'd0, busy}, 32'd0);
    check({nm, " pulse_len"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    vec_t vecs[8];
    logic [1:0] cell_in;
    int unsigned hs_cyc[4], rsp_n, hs_n, bad, c;
    logic hs_id[4], rs_id[4];

    vecs[0] = '{1'b1, 1'b0, 8'hA5, 8'hA5, 1'b0, 1'b1, 4'd8, 4'd8, 9};
    vecs[1] = '{1'b0, 1'b1, 8'hF0, 8'h0F, 1'b1, 1'b0, 4'd0, 4'd0, 2};
    vecs[2] = '{1'b1, 1'b0, 8'hFF, 8'hFE, 1'b0, 1'b0, 4'd7, 4'd0, 2};
    vecs[3] = '{1'b1, 1'b0, 8'h7F, 8'hFF, 1'b0, 1'b0, 4'd7, 4'd7, 9};
    vecs[4] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 4'd8, 4'd8, 9};
    vecs[5] = '{1'b0, 1'b1, 8'h3C, 8'hC3, 1'b1, 1'b0, 4'd0, 4'd0, 2};
    vecs[6] = '{1'b1, 1'b0, 8'hAA, 8'hA0, 1'b0, 1'b0, 4'd6, 4'd1, 3};
    vecs[7] = '{1'b1, 1'b1, 8'hC3, 8'hC3, 1'b1, 1'b1, 4'd8, 4'd8, 9};

    for (int unsigned i = 0; i < 4; i++) begin
      cell_in = 2'(i);
      ca = cell_in[1]; cb = cell_in[0];
      #1;
      check($sformatf("cell a=%0d b=%0d", ca, cb), {31'd0, cs}, {31'd0, ca == cb});
    end

    do_reset();
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset rsp_id", {31'd0, rsp_id}, 32'd0);
    check("reset rsp_eq", {31'd0, rsp_eq}, 32'd0);
    check("reset rsp_cnt", {28'd0, rsp_match_cnt}, 32'd0);
    check("reset ready", {30'd0, req0_ready, req1_ready}, 32'd0);

    for (int unsigned i = 0; i < 8; i++) begin
      run_req($sformatf("vec%0d", i), vecs[i].v0, vecs[i].v1, vecs[i].a, vecs[i].b,
              vecs[i].a, vecs[i].b, vecs[i].id, vecs[i].eq,
              EE ? vecs[i].cnt_ee : vecs[i].cnt_full, EE ? vecs[i].lat_ee : 9);
    end

    // Both requesters held valid from reset: grants must alternate 0,1,0,1.
    do_reset();
    req0_valid = 1'b1; req0_a = 8'h55; req0_b = 8'h55;
    req1_valid = 1'b1; req1_a = 8'h3C; req1_b = 8'h3C;
    #1;
    hs_n = 0; rsp_n = 0; bad = 0; c = 0;
    while ((rsp_n < 4) && c < 60) begin
      if (busy && (req0_ready || req1_ready)) bad++;
      if (req0_ready && req1_ready) bad++;
      if ((req0_ready || req1_ready) && hs_n < 4) begin
        hs_cyc[hs_n] = c; hs_id[hs_n] = req1_ready; hs_n++;
      end
      if (rsp_valid && rsp_n < 4) begin
        rs_id[rsp_n] = rsp_id; rsp_n++;
      end
      step();
      c++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("alt handshakes", hs_n, 4);
    check("alt responses", rsp_n, 4);
    check("alt ready_while_busy", bad, 0);
    for (int unsigned i = 0; i < 4; i++) begin
      if (i < hs_n) check($sformatf("alt grant%0d", i), {31'd0, hs_id[i]}, i % 2);
      if (i < rsp_n) check($sformatf("alt rsp_id%0d", i), {31'd0, rs_id[i]}, i % 2);
      if (i > 0 && i < hs_n)
        check($sformatf("alt spacing%0d", i), hs_cyc[i] - hs_cyc[i-1], 10);
    end
    repeat (12) step();

    // Reset in the middle of an operation aborts it silently.
    do_reset();
    req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h11;
    #1;
    check("abort handshake", {31'd0, req0_ready}, 32'd1);
    step();
    req0_valid = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort rsp_valid", {31'd0, rsp_valid}, 32'd0);
    bad = 0;
    for (int unsigned i = 0; i < 12; i++) begin
      if (rsp_valid) bad++;
      step();
    end
    check("abort no_rsp", bad, 0);
    run_req("post_abort_tie", 1'b1, 1'b1, 8'h5A, 8'h5A, 8'h0F, 8'hF0,
            1'b0, 1'b1, 4'd8, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
